// File: rtl/alu_pkg.sv
// Shared ALUCtrl opcode constants and the multiply/divide FSM state encoding.
package alu_pkg;
  localparam logic [4:0] ALU_AND  = 5'h00;
  localparam logic [4:0] ALU_OR   = 5'h01;
  localparam logic [4:0] ALU_ADD  = 5'h02;
  localparam logic [4:0] ALU_SLL  = 5'h03;
  localparam logic [4:0] ALU_SRL  = 5'h04;
  localparam logic [4:0] ALU_SUB  = 5'h06;
  localparam logic [4:0] ALU_SLT  = 5'h07;
  localparam logic [4:0] ALU_ADDU = 5'h08;
  localparam logic [4:0] ALU_SUBU = 5'h09;
  localparam logic [4:0] ALU_XOR  = 5'h0A;
  localparam logic [4:0] ALU_SLTU = 5'h0B;
  localparam logic [4:0] ALU_NOR  = 5'h0C;
  localparam logic [4:0] ALU_SRA  = 5'h0D;
  localparam logic [4:0] ALU_LUI  = 5'h0E;
  localparam logic [4:0] ALU_MULT  = 5'h10;
  localparam logic [4:0] ALU_MULTU = 5'h11;
  localparam logic [4:0] ALU_DIV   = 5'h12;
  localparam logic [4:0] ALU_DIVU  = 5'h13;
  localparam logic [4:0] ALU_MFHI  = 5'h14;
  localparam logic [4:0] ALU_MFLO  = 5'h15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_mdu_core.sv
// Iterative multiply/divide unit with the HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, both on
// operand magnitudes with a sign fix-up applied as HI/LO are written.
// Ports: i_clk, i_rst (async active-high), i_start, i_op (ALUCtrl),
//        i_a/i_b operands; o_hi/o_lo, o_busy (RUN), o_done (DONE),
//        o_divzero (with o_done when divisor was zero).
// Config: ALU_MDU_DIV_EN enables DIV/DIVU; otherwise they never launch.
module alu_mdu_core import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_divzero
);
  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_div, r_neg_q, r_neg_r, r_bzero, r_divz;
  logic [WIDTH-1:0] r_dvd, r_opb, r_acc_lo, r_hi, r_lo;
  logic [WIDTH:0]   r_acc_hi;   // mul: upper product half; div: partial remainder

  logic             w_div_ok, w_launch, w_signed, w_a_neg, w_b_neg, w_last, w_ge;
  logic [WIDTH-1:0] w_acc_lo_n, w_fin_hi, w_fin_lo;
  logic [WIDTH:0]   w_acc_hi_n, w_sum, w_sh;
  logic [2*WIDTH-1:0] w_prod;

`ifdef ALU_MDU_DIV_EN
  assign w_div_ok = (i_op == ALU_DIV) || (i_op == ALU_DIVU);
`else
  assign w_div_ok = 1'b0;
`endif

  assign w_launch = i_start && (r_state != ST_RUN) &&
                    ((i_op == ALU_MULT) || (i_op == ALU_MULTU) || w_div_ok);
  assign w_signed = (i_op == ALU_MULT) || (i_op == ALU_DIV);
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // one iteration step and the signed fix-up of the final step
  always_comb begin
    w_sum = r_acc_hi + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
    w_sh  = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
    w_ge  = (w_sh >= {1'b0, r_opb});
    if (r_div) begin
      w_acc_hi_n = w_ge ? (w_sh - {1'b0, r_opb}) : w_sh;
      w_acc_lo_n = {r_acc_lo[WIDTH-2:0], w_ge};
    end else begin
      w_acc_hi_n = {1'b0, w_sum[WIDTH:1]};
      w_acc_lo_n = {w_sum[0], r_acc_lo[WIDTH-1:1]};
    end
    w_prod = {w_acc_hi_n[WIDTH-1:0], w_acc_lo_n};
    if (r_neg_q) w_prod = -w_prod;
    if (!r_div) begin
      {w_fin_hi, w_fin_lo} = w_prod;
    end else if (r_bzero) begin
      w_fin_lo = '1;
      w_fin_hi = r_dvd;
    end else begin
      w_fin_lo = r_neg_q ? -w_acc_lo_n : w_acc_lo_n;
      w_fin_hi = r_neg_r ? -w_acc_hi_n[WIDTH-1:0] : w_acc_hi_n[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_next = ST_RUN;
      ST_RUN:  if (w_last)   w_next = ST_DONE;
      ST_DONE: w_next = w_launch ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_divz   <= 1'b0;
      r_dvd    <= '0;
      r_opb    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_divz <= (r_state == ST_RUN) && w_last && r_div && r_bzero;
      if (w_launch) begin
        r_cnt    <= '0;
        r_div    <= w_div_ok;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_bzero  <= (i_b == '0);
        r_dvd    <= i_a;
        r_opb    <= w_b_neg ? -i_b : i_b;
        r_acc_hi <= '0;
        r_acc_lo <= w_a_neg ? -i_a : i_a;
      end else if (r_state == ST_RUN) begin
        r_cnt    <= r_cnt + CW'(1);
        r_acc_hi <= w_acc_hi_n;
        r_acc_lo <= w_acc_lo_n;
        if (w_last) begin
          r_hi <= w_fin_hi;
          r_lo <= w_fin_lo;
        end
      end
    end
  end

  assign o_hi      = r_hi;
  assign o_lo      = r_lo;
  assign o_busy    = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);
  assign o_divzero = r_divz;
endmodule

// File: rtl/alu_mdu.sv
// ALU with an attached iterative multiply/divide unit.
// Single-cycle ops are purely combinational on BusW/Zero/Overflow; MD ops
// run in alu_mdu_core and are read back with MFHI/MFLO.
// Ports: CLK, Reset (async active-high), BusA, BusB, ALUCtrl, Start;
//        BusW, Zero, Overflow, Busy, Done, DivZero, Stall.
// Config: ALU_MDU_DIV_EN enables DIV/DIVU (otherwise codes 12h/13h unused).
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       ALUCtrl,
  input  logic             Start,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Stall
);
  logic [WIDTH-1:0] w_hi, w_lo, w_sum, w_diff, w_res;
  logic [4:0]       w_shamt;
  logic             w_ovf;

  alu_mdu_core #(.WIDTH(WIDTH)) u_core (
    .i_clk(CLK), .i_rst(Reset), .i_start(Start), .i_op(ALUCtrl),
    .i_a(BusA), .i_b(BusB), .o_hi(w_hi), .o_lo(w_lo),
    .o_busy(Busy), .o_done(Done), .o_divzero(DivZero)
  );

  assign w_shamt = BusA[4:0];
  assign w_sum   = BusA + BusB;
  assign w_diff  = BusA - BusB;

  // MD launch codes and unused codes fall through to zero
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUCtrl)
      ALU_AND:  w_res = BusA & BusB;
      ALU_OR:   w_res = BusA | BusB;
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (w_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (w_diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_ADDU: w_res = w_sum;
      ALU_SUBU: w_res = w_diff;
      ALU_SLL:  w_res = BusB << w_shamt;
      ALU_SRL:  w_res = BusB >> w_shamt;
      ALU_SRA:  w_res = $signed(BusB) >>> w_shamt;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (BusA < BusB)};
      ALU_XOR:  w_res = BusA ^ BusB;
      ALU_NOR:  w_res = ~(BusA | BusB);
      ALU_LUI:  w_res = BusB << 16;
      ALU_MFHI: w_res = w_hi;
      ALU_MFLO: w_res = w_lo;
      default:  w_res = '0;
    endcase
  end

  assign BusW     = w_res;
  assign Zero     = (w_res == '0);
  assign Overflow = w_ovf;
  assign Stall    = Busy && ((ALUCtrl == ALU_MFHI) || (ALUCtrl == ALU_MFLO));
endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  import alu_pkg::*;

  logic        CLK = 1'b0, Reset;
  logic [31:0] BusA, BusB, BusW;
  logic [4:0]  ALUCtrl;
  logic        Start, Zero, Overflow, Busy, Done, DivZero, Stall;

  logic [7:0]  a8, b8, w8;
  logic [4:0]  c8;
  logic        s8, z8, v8, busy8, done8, dz8, st8;

  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  alu_mdu #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
    .Start(Start), .BusW(BusW), .Zero(Zero), .Overflow(Overflow),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Stall(Stall)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .Reset(Reset), .BusA(a8), .BusB(b8), .ALUCtrl(c8),
    .Start(s8), .BusW(w8), .Zero(z8), .Overflow(v8),
    .Busy(busy8), .Done(done8), .DivZero(dz8), .Stall(st8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ALUCtrl = op; BusA = a; BusB = b;
    #1;
  endtask

  // launch an MD op, scramble operands, wait (bounded) for Done, read HI/LO
  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int nbusy);
    int n;
    ALUCtrl = op; BusA = a; BusB = b; Start = 1'b1;
    tick();
    Start = 1'b0; BusA = 32'h1234_5678; BusB = 32'h0;
    nbusy = 0; n = 0;
    while (!Done && n < 100) begin
      if (Busy) nbusy++;
      tick();
      n++;
    end
    if (!Done) chk("md_timeout", 64'd0, 64'd1);
    dz = DivZero;
    ALUCtrl = ALU_MFHI; #1 hi = BusW;
    ALUCtrl = ALU_MFLO; #1 lo = BusW;
  endtask

  initial begin
    logic [31:0] hi, lo;
    logic        dz, seen;
    int          nb;

    Reset = 1'b1; Start = 1'b0; BusA = '0; BusB = '0; ALUCtrl = ALU_MFHI;
    a8 = '0; b8 = '0; c8 = ALU_AND; s8 = 1'b0;
    tick(); tick();
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_hi", {32'd0, BusW}, 64'd0);
    Reset = 1'b0;
    tick();

    // single-cycle ops
    alu(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    chk("add", {32'd0, BusW}, 64'h8000_0000);
    chk("add_ovf", {63'd0, Overflow}, 64'd1);
    alu(ALU_ADDU, 32'h7FFF_FFFF, 32'h1);
    chk("addu_ovf", {63'd0, Overflow}, 64'd0);
    alu(ALU_SUB, 32'h8000_0000, 32'h1);
    chk("sub", {32'd0, BusW}, 64'h7FFF_FFFF);
    chk("sub_ovf", {63'd0, Overflow}, 64'd1);
    alu(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
    chk("and", {32'd0, BusW}, 64'h0000_F000);
    alu(ALU_SLT, 32'hFFFF_FFFF, 32'h1);
    chk("slt", {32'd0, BusW}, 64'd1);
    alu(ALU_SLTU, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", {32'd0, BusW}, 64'd0);
    alu(ALU_SRA, 32'd4, 32'h8000_0000);
    chk("sra", {32'd0, BusW}, 64'hF800_0000);
    alu(ALU_SRL, 32'd4, 32'h8000_0000);
    chk("srl", {32'd0, BusW}, 64'h0800_0000);
    alu(ALU_SLL, 32'd31, 32'h1);
    chk("sll", {32'd0, BusW}, 64'h8000_0000);
    alu(ALU_LUI, 32'h0, 32'hABCD_1234);
    chk("lui", {32'd0, BusW}, 64'h1234_0000);
    alu(ALU_NOR, 32'h0, 32'h0);
    chk("nor", {32'd0, BusW}, 64'hFFFF_FFFF);
    chk("nor_zero", {63'd0, Zero}, 64'd0);
    alu(ALU_XOR, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    chk("xor_zero", {63'd0, Zero}, 64'd1);
    alu(5'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("unused05", {32'd0, BusW}, 64'd0);
    alu(ALU_MULT, 32'hFFFF_FFFF, 32'h3);
    chk("md_code_busw", {32'd0, BusW}, 64'd0);
    alu(ALU_MFLO, 32'h0, 32'h0);
    chk("stall_idle", {63'd0, Stall}, 64'd0);

    // MULT -3 x 5: Busy cycles 1..32, Done cycle 33, stall/old LO, Start in RUN ignored
    ALUCtrl = ALU_MULT; BusA = 32'hFFFF_FFFD; BusB = 32'd5; Start = 1'b1;
    tick();
    Start = 1'b0; BusA = 32'h7; BusB = 32'h9;
    nb = 0;
    for (int c = 1; c <= 32; c++) begin
      if (Busy && !Done) nb++;
      if (c == 10) begin
        ALUCtrl = ALU_MFLO; #1;
        chk("stall_run", {63'd0, Stall}, 64'd1);
        chk("old_lo", {32'd0, BusW}, 64'd0);
      end
      if (c == 15) begin ALUCtrl = ALU_MULTU; Start = 1'b1; end
      if (c == 16) Start = 1'b0;
      tick();
    end
    chk("mult_busy_cycles", nb, 64'd32);
    chk("mult_done", {62'd0, Done, Busy}, 64'd2);
    ALUCtrl = ALU_MFHI; #1;
    chk("mult_hi", {32'd0, BusW}, 64'hFFFF_FFFF);
    chk("stall_done", {63'd0, Stall}, 64'd0);
    ALUCtrl = ALU_MFLO; #1;
    chk("mult_lo", {32'd0, BusW}, 64'hFFFF_FFF1);

    // relaunch from DONE
    ALUCtrl = ALU_MULTU; BusA = 32'd3; BusB = 32'd4; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("relaunch_busy", {63'd0, Busy}, 64'd1);
    repeat (32) tick();
    chk("relaunch_done", {63'd0, Done}, 64'd1);
    ALUCtrl = ALU_MFLO; #1;
    chk("multu_lo", {32'd0, BusW}, 64'd12);

    // reset at RUN cycle 10 aborts with no Done
    tick();
    ALUCtrl = ALU_MULTU; BusA = 32'd2; BusB = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    Reset = 1'b1; #1;
    chk("rst_run_busy", {63'd0, Busy}, 64'd0);
    ALUCtrl = ALU_MFLO; #1;
    chk("rst_run_lo", {32'd0, BusW}, 64'd0);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); seen |= Done | Busy; end
    chk("rst_no_done", {63'd0, seen}, 64'd0);

    // Start with a non-MD code is ignored
    ALUCtrl = ALU_ADD; Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_nonmd", {63'd0, Busy}, 64'd0);

    run_md(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dz, nb);
    chk("multu_big", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_md(ALU_MULT, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dz, nb);
    chk("mult_mneg", {hi, lo}, 64'h0000_0000_8000_0000);
    run_md(ALU_MULT, 32'h0000_0007, 32'hFFFF_FFFA, hi, lo, dz, nb);
    chk("mult_7xm6", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

`ifdef ALU_MDU_DIV_EN
    run_md(ALU_DIV, 32'hFFFF_FFF9, 32'd2, hi, lo, dz, nb);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_m7_2_dz", {63'd0, dz}, 64'd0);
    run_md(ALU_DIVU, 32'd7, 32'd0, hi, lo, dz, nb);
    chk("divu_7_0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    chk("divu_7_0_dz", {63'd0, dz}, 64'd1);
    chk("divu_7_0_lat", nb, 64'd32);
    run_md(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dz, nb);
    chk("div_mneg", {hi, lo}, 64'h0000_0000_8000_0000);
    chk("div_mneg_dz", {63'd0, dz}, 64'd0);
    run_md(ALU_DIV, 32'd7, 32'hFFFF_FFFE, hi, lo, dz, nb);
    chk("div_7_m2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
    run_md(ALU_DIV, 32'hFFFF_FFFB, 32'd0, hi, lo, dz, nb);
    chk("div_m5_0", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    run_md(ALU_DIVU, 32'd100, 32'd7, hi, lo, dz, nb);
    chk("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);
`else
    tick();
    ALUCtrl = ALU_DIVU; BusA = 32'd7; BusB = 32'd0; Start = 1'b1; #1;
    chk("nodiv_busw", {32'd0, BusW}, 64'd0);
    tick();
    Start = 1'b0;
    chk("nodiv_busy", {63'd0, Busy}, 64'd0);
    seen = 1'b0;
    repeat (40) begin tick(); seen |= Done | DivZero; end
    chk("nodiv_done", {63'd0, seen}, 64'd0);
`endif

    // WIDTH=8 instance
    c8 = ALU_ADD; a8 = 8'h7F; b8 = 8'h01; #1;
    chk("w8_add", {56'd0, w8}, 64'h80);
    chk("w8_ovf", {63'd0, v8}, 64'd1);
    c8 = ALU_MULTU; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
    tick();
    s8 = 1'b0; a8 = 8'h00;
    nb = 0;
    for (int n = 0; n < 40 && !done8; n++) begin
      if (busy8) nb++;
      tick();
    end
    chk("w8_done", {63'd0, done8}, 64'd1);
    chk("w8_busy_cycles", nb, 64'd8);
    c8 = ALU_MFHI; #1;
    chk("w8_hi", {56'd0, w8}, 64'hFE);
    c8 = ALU_MFLO; #1;
    chk("w8_lo", {56'd0, w8}, 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits; legal values are even integers of 8 or more.
REQ-002 Port: CLK  in  1  clock; all state updates on its rising edge.
REQ-003 Port: Reset  in  1  asynchronous, active-high reset.
REQ-004 Port: BusA  in  WIDTH  operand A; the dividend for divide operations.
REQ-005 Port: BusB  in  WIDTH  operand B; shift amount is BusA[4:0] for SLL/SRL/SRA.
REQ-006 Port: ALUCtrl  in  5  operation code; bit 4 = 0 selects a single-cycle op, bit 4 = 1 selects a multiply/divide (MD) op.
REQ-007 Port: Start  in  1  launches the MD op on ALUCtrl (10h-13h), sampled on the CLK edge.
REQ-008 Port: BusW  out  WIDTH  result.
REQ-009 Port: Zero  out  1  high when BusW is all zeros.
REQ-010 Port: Overflow  out  1  high on signed overflow for ADD or SUB; low otherwise.
REQ-011 Port: Busy  out  1  an MD op is in progress.
REQ-012 Port: Done  out  1  one-cycle pulse when HI/LO have just been written.
REQ-013 Port: DivZero  out  1  pulses together with Done when a divide had a zero divisor.
REQ-014 Port: Stall  out  1  high when MFHI or MFLO is selected while Busy is high.

Function
REQ-015 Single-cycle ops SHALL be combinational on BusW, using codes 00h AND, 01h OR, 02h ADD, 03h SLL, 04h SRL, 06h SUB, 07h SLT, 08h ADDU, 09h SUBU, 0Ah XOR, 0Bh SLTU, 0Ch NOR, 0Dh SRA, 0Eh LUI (BusB[15:0] shifted left by 16).
REQ-016 Unused codes (05h, 0Fh, 16h-1Fh) SHALL drive BusW = 0.
REQ-017 MD codes SHALL be: 10h MULT, 11h MULTU, 12h DIV, 13h DIVU, 14h MFHI (BusW = HI), 15h MFLO (BusW = LO).
REQ-018 While an MD op code (10h-13h) is on ALUCtrl, BusW SHALL be 0.
REQ-019 The FSM SHALL have states IDLE, RUN and DONE.
REQ-020 IDLE or DONE with Start high and an MD op code SHALL latch the operands and ALUCtrl and go to RUN.
REQ-021 RUN SHALL last exactly WIDTH cycles (one bit per cycle, iterative shift-add or restoring divide), then go to DONE.
REQ-022 DONE SHALL last one cycle and write HI/LO; it returns to IDLE unless Start relaunches.
REQ-023 Busy SHALL be high exactly while the FSM is in RUN; Done SHALL be high exactly while it is in DONE.
REQ-024 Start while in RUN SHALL be ignored, and Start with a non-MD code SHALL be ignored.
REQ-025 Multiply SHALL write the product as {HI,LO} (2*WIDTH bits); MULT is signed, MULTU is unsigned.
REQ-026 Divide SHALL write LO = quotient and HI = remainder.
REQ-027 Signed divide SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-028 DIV of most-negative by -1 SHALL give LO = most-negative and HI = 0, with no flag.
REQ-029 Divide by zero SHALL give LO = all ones and HI = dividend, with DivZero high during DONE and normal latency.
REQ-030 MFHI/MFLO issued during RUN SHALL return the old HI/LO with Stall high; in DONE they SHALL return the new values.
REQ-031 Operand changes after launch SHALL have no effect on the MD result.

Reset
REQ-032 Reset SHALL immediately (asynchronously) force state IDLE, HI = LO = 0, and Busy = Done = DivZero = 0.
REQ-033 Reset during RUN SHALL abort the op with no HI/LO write.
REQ-034 BusW, Zero and Overflow SHALL remain combinational and are not reset.

Configuration
REQ-035 With macro ALU_MDU_DIV_EN defined, DIV and DIVU SHALL be implemented as specified.
REQ-036 Without ALU_MDU_DIV_EN, codes 12h/13h SHALL be treated as unused: Start is ignored, BusW = 0, and DivZero is tied low.

Structure
REQ-037 Shared package alu_pkg SHALL hold the 5-bit ALUCtrl code constants and the FSM state encoding (IDLE/RUN/DONE).
REQ-038 The iterative multiply/divide datapath and FSM SHALL be a sub-module named alu_mdu_core; alu_mdu holds the single-cycle ops, result mux and Stall.

Verification
REQ-039 ADD 7FFFFFFFh + 1 -> BusW = 80000000h, Overflow = 1; ADDU of the same operands -> Overflow = 0.
REQ-040 MULT FFFFFFFDh x 5 with Start at cycle 0 -> Busy in cycles 1-32, Done in cycle 33, HI = FFFFFFFFh, LO = FFFFFFF1h.
REQ-041 DIV -7 / 2 -> LO = FFFFFFFDh, HI = FFFFFFFFh; DIVU 7 / 0 -> LO = FFFFFFFFh, HI = 7, DivZero = 1 in the Done cycle.
REQ-042 Reset asserted at RUN cycle 10 -> Busy = 0 at once, HI = LO = 0, no Done pulse.
REQ-043 MFLO during RUN -> Stall = 1 with the old LO; Start in RUN ignored; Start in DONE -> Busy high in the next cycle.
REQ-044 WIDTH = 8 build: MULTU FFh x FFh -> HI = FEh, LO = 01h after 8 RUN cycles.
